// File: rtl/mul_ctrl.sv
// rtl/mul_ctrl.sv - RV32M multiply sequencer: multicycle operand hold, product capture, one-entry product cache
module mul_ctrl #(
    parameter int MUL_CYCLES = 2,
    parameter bit CACHE_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        kill,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] rd_data,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic [1:0]  mul_op,
    input  logic [63:0] mul_f
);

    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   mul_a_q, mul_a_d;
    logic [31:0]   mul_b_q, mul_b_d;
    logic [1:0]    mul_op_q, mul_op_d;
    logic          lo_sel_q, lo_sel_d;
    logic [63:0]   prod_q, prod_d;
    logic [31:0]   tag_a_q, tag_a_d;
    logic [31:0]   tag_b_q, tag_b_d;
    logic [1:0]    tag_op_q, tag_op_d;
    logic          cache_vld_q, cache_vld_d;
    logic [31:0]   rd_data_q, rd_data_d;

    logic [1:0]    req_op;
    logic          hit;

    always_comb begin
        req_op = (funct3 == 2'd0) ? 2'd1 : funct3;
        // MUL's low half is identical for every signedness, so it hits on any cached op
        hit    = (CACHE_EN != 1'b0) && cache_vld_q && (rs1 == tag_a_q) && (rs2 == tag_b_q)
                 && ((funct3 == 2'd0) || (req_op == tag_op_q));
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_op_d    = mul_op_q;
        lo_sel_d    = lo_sel_q;
        prod_d      = prod_q;
        tag_a_d     = tag_a_q;
        tag_b_d     = tag_b_q;
        tag_op_d    = tag_op_q;
        cache_vld_d = cache_vld_q;
        rd_data_d   = rd_data_q;
        case (state_q)
            IDLE, DONE: begin
                if (start && !kill) begin
                    if (hit) begin
                        state_d   = DONE;
                        rd_data_d = (funct3 == 2'd0) ? prod_q[31:0] : prod_q[63:32];
                    end else begin
                        state_d  = CALC;
                        mul_a_d  = rs1;
                        mul_b_d  = rs2;
                        mul_op_d = req_op;
                        lo_sel_d = (funct3 == 2'd0);
                        cnt_d    = CW'(MUL_CYCLES - 1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (kill) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d     = DONE;
                    prod_d      = mul_f;
                    tag_a_d     = mul_a_q;
                    tag_b_d     = mul_b_q;
                    tag_op_d    = mul_op_q;
                    cache_vld_d = 1'b1;
                    rd_data_d   = lo_sel_q ? mul_f[31:0] : mul_f[63:32];
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_op_q    <= 2'd1;
            lo_sel_q    <= 1'b0;
            prod_q      <= '0;
            tag_a_q     <= '0;
            tag_b_q     <= '0;
            tag_op_q    <= '0;
            cache_vld_q <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_op_q    <= mul_op_d;
            lo_sel_q    <= lo_sel_d;
            prod_q      <= prod_d;
            tag_a_q     <= tag_a_d;
            tag_b_q     <= tag_b_d;
            tag_op_q    <= tag_op_d;
            cache_vld_q <= cache_vld_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign ready   = (state_q != CALC);
    assign busy    = (state_q == CALC);
    assign done    = (state_q == DONE);
    assign rd_data = rd_data_q;
    assign mul_a   = mul_a_q;
    assign mul_b   = mul_b_q;
    assign mul_op  = mul_op_q;

endmodule

// File: tb/tb_mul_ctrl.sv
// tb/tb_mul_ctrl.sv - scoreboard bench for mul_ctrl with a behavioural multiplier and cache model
module tb_mul_ctrl;
    localparam int MC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, kill, start1;
    logic [1:0]  funct3, funct3_1;
    logic [31:0] rs1, rs2, rs1_1, rs2_1;
    logic        ready, busy, done, ready1, busy1, done1;
    logic [31:0] rd_data, mul_a, mul_b, rd_data1, mul_a1, mul_b1;
    logic [1:0]  mul_op, mul_op1;
    logic [63:0] mul_f, mul_f1;

    function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        logic [63:0] xa, xb;
        xa = (op == 2'd3) ? {32'b0, a} : {{32{a[31]}}, a};
        xb = (op == 2'd1) ? {{32{b[31]}}, b} : {32'b0, b};
        return xa * xb;
    endfunction

    assign mul_f  = mul_model(mul_a, mul_b, mul_op);
    assign mul_f1 = mul_model(mul_a1, mul_b1, mul_op1);

    mul_ctrl #(.MUL_CYCLES(MC), .CACHE_EN(1'b1)) dut (
        .clk(clk), .rst(rst_n), .start(start), .funct3(funct3), .rs1(rs1), .rs2(rs2), .kill(kill),
        .ready(ready), .busy(busy), .done(done), .rd_data(rd_data),
        .mul_a(mul_a), .mul_b(mul_b), .mul_op(mul_op), .mul_f(mul_f));

    mul_ctrl #(.MUL_CYCLES(MC), .CACHE_EN(1'b0)) dut_nc (
        .clk(clk), .rst(rst_n), .start(start1), .funct3(funct3_1), .rs1(rs1_1), .rs2(rs2_1), .kill(1'b0),
        .ready(ready1), .busy(busy1), .done(done1), .rd_data(rd_data1),
        .mul_a(mul_a1), .mul_b(mul_b1), .mul_op(mul_op1), .mul_f(mul_f1));

    int checks = 0, failures = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {logic [31:0] res; int issue; int lat;} exp_t;
    exp_t sb[$];
    logic [31:0] last_rd = '0, ea = '0, eb = '0;
    logic [1:0]  eop = 2'd1;
    bit          mon_en = 1'b0;
    bit          c_vld = 1'b0;
    logic [31:0] c_a, c_b;
    logic [1:0]  c_op;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (done) begin
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_done actual=%0h expected=none", rd_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rd_data", rd_data, e.res);
                    check("latency", cyc - e.issue, e.lat);
                    check("busy_at_done", busy, 0);
                    last_rd = e.res;
                end
            end else begin
                check("rd_hold", rd_data, last_rd);
            end
            if (busy) begin
                check("calc_operands", {mul_a, mul_b, mul_op}, {ea, eb, eop});
                check("ready_in_calc", ready, 0);
            end
        end
    end

    function automatic logic [1:0] map_op(input logic [1:0] f3);
        return (f3 == 2'd0) ? 2'd1 : f3;
    endfunction

    function automatic logic [31:0] ref_result(input logic [1:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = mul_model(a, b, map_op(f3));
        return (f3 == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // Called at a negedge with ready=1; returns at a negedge with ready=1.
    task automatic issue(input logic [1:0] f3, input logic [31:0] a, input logic [31:0] b, input bit kill_it);
        logic [1:0] op;
        bit hit;
        exp_t e;
        op  = map_op(f3);
        hit = c_vld && (a == c_a) && (b == c_b) && ((f3 == 2'd0) || (op == c_op));
        funct3 = f3; rs1 = a; rs2 = b; start = 1'b1; kill = 1'b0;
        if (hit || !kill_it) begin
            e.res = ref_result(f3, a, b); e.issue = cyc; e.lat = hit ? 1 : MC + 1;
            sb.push_back(e);
        end
        if (!hit) begin ea = a; eb = b; eop = op; end
        @(negedge clk);
        start = 1'b0;
        if (hit) return;
        if (kill_it) begin
            kill = 1'b1;
            @(negedge clk);
            kill = 1'b0;
            check("kill_to_idle", {ready, busy, done}, 3'b100);
            return;
        end
        for (int i = 1; i <= MC; i++) begin
            start = 1'($urandom_range(0, 1)); funct3 = 2'($urandom); rs1 = $urandom; rs2 = $urandom;
            @(negedge clk);
        end
        start = 1'b0;
        c_vld = 1'b1; c_a = a; c_b = b; c_op = op;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0: return 32'hFFFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'd7;
            3: return 32'd6;
            default: return $urandom;
        endcase
    endfunction

    task automatic nc_run(input logic [1:0] f3, input logic [31:0] a, input logic [31:0] b);
        int t0;
        bit seen;
        funct3_1 = f3; rs1_1 = a; rs2_1 = b; start1 = 1'b1; t0 = cyc; seen = 0;
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done1) seen = 1;
            else @(negedge clk);
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL nc_timeout actual=no_done expected=done");
        end else begin
            check("nc_latency", cyc - t0, MC + 1);
            check("nc_rd_data", rd_data1, ref_result(f3, a, b));
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; kill = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
        start1 = 1'b0; funct3_1 = '0; rs1_1 = '0; rs2_1 = '0;
        repeat (2) @(negedge clk);
        check("reset_flags", {ready, busy, done}, 3'b100);
        check("reset_rd_data", rd_data, 0);
        check("reset_mul_if", {mul_a, mul_b, mul_op}, {64'h0, 2'd1});
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        issue(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        issue(2'd1, 32'h8000_0000, 32'h8000_0000, 0);
        issue(2'd2, 32'h8000_0000, 32'h8000_0000, 0);
        issue(2'd0, 32'd7, 32'd6, 1);
        issue(2'd0, 32'd7, 32'd6, 0);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0: begin start = 1'b0; @(negedge clk); end
                1: begin
                    start = 1'b1; kill = 1'b1; funct3 = 2'($urandom); rs1 = pick(); rs2 = pick();
                    @(negedge clk);
                    start = 1'b0; kill = 1'b0;
                    check("kill_dominates_start", {ready, busy, done}, 3'b100);
                end
                default: issue(2'($urandom), pick(), pick(), $urandom_range(0, 7) == 0);
            endcase
        end

        // asynchronous reset in the middle of a calculation
        ea = 32'd12345; eb = 32'd999; eop = 2'd3;
        funct3 = 2'd3; rs1 = ea; rs2 = eb; start = 1'b1;
        if (c_vld && c_a == ea && c_b == eb) c_vld = 1'b0;
        @(negedge clk);
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_flags", {ready, busy, done}, 3'b100);
        check("async_rst_rd_data", rd_data, 0);
        check("async_rst_mul_if", {mul_a, mul_b, mul_op}, {64'h0, 2'd1});
        sb.delete(); last_rd = '0; c_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(2'd3, 32'd12345, 32'd999, 0);
        issue(2'd0, 32'd12345, 32'd999, 0);
        repeat (4) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        mon_en = 1'b0;

        nc_run(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        nc_run(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mul_ctrl.md
Name: mul_ctrl

Overview:
- Sequencing controller for the combinational Wallace-tree multiplier (operands a/b, op select, 64-bit product) in the RV32M execute stage.
- Accepts MUL/MULH/MULHSU/MULHU requests from EX, holds operands stable for a multicycle window, captures the product and returns the selected 32-bit half.
- Keeps a one-entry product cache so a MULH*/MUL pair on identical operands completes the second op in one cycle.
- Drives a busy/stall to the pipeline and honours a kill (flush) request.

Parameters:
- MUL_CYCLES, 2, cycles operands are held at the multiplier before the product is captured (≥1).
- CACHE_EN, 1, 1 = enable the one-entry product cache; 0 = every request misses.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- start  in  1  request valid; sampled only when ready=1.
- funct3  in  2  0=MUL, 1=MULH, 2=MULHSU, 3=MULHU.
- rs1  in  32  operand A.
- rs2  in  32  operand B.
- kill  in  1  pipeline flush; aborts an in-flight request.
- ready  out  1  1 when not in CALC.
- busy  out  1  1 in CALC (stall to pipeline).
- done  out  1  one-cycle pulse; rd_data valid.
- rd_data  out  32  result; held until the next done.
- mul_a  out  32  to multiplier a.
- mul_b  out  32  to multiplier b.
- mul_op  out  2  to multiplier: 1=signed×signed, 2=signed×unsigned, 3=unsigned×unsigned.
- mul_f  in  64  product from multiplier.

Behaviour:
- Reset (async, rst=0): state IDLE; done=0, busy=0, ready=1, rd_data=0, mul_a=0, mul_b=0, mul_op=1, cache invalid, all operand/product registers 0. Takes effect immediately, including mid-CALC; no done is produced.
- States: IDLE, CALC, DONE.
- Request op mapping: MUL→1, MULH→1, MULHSU→2, MULHU→3.
- Cache hit: cache valid, rs1==tag_a and rs2==tag_b, and either funct3=MUL (any cached op) or the request's mapped op == cached op.
- IDLE/DONE with start=1, kill=0:
  - Hit: go to DONE; rd_data from the cached product; mul_* unchanged.
  - Miss: register rs1, rs2 and the mapped op onto mul_a/mul_b/mul_op; load counter = MUL_CYCLES-1; go to CALC.
- IDLE/DONE with start=0, or kill=1: go to IDLE. Kill dominates start.
- CALC:
  - Counter decrements each cycle. At count 0: capture mul_f into the product register; cache tag = (mul_a, mul_b, mul_op); cache valid=1; go to DONE.
  - start is ignored (ready=0).
  - kill=1: go to IDLE at the next edge; no capture, cache unchanged, no done.
- DONE: done=1 for exactly this cycle. A new start in this cycle is accepted, so back-to-back requests are supported. kill has no effect on an already-asserted done.
- Latency: start sampled in cycle 0. A hit asserts done in cycle 1. A miss holds CALC in cycles 1..MUL_CYCLES and asserts done in cycle MUL_CYCLES+1.
- rd_data: product[31:0] for MUL, product[63:32] otherwise. Registered and updated only on entry to DONE; stable between done pulses.
- mul_a/mul_b/mul_op stay constant throughout CALC (multicycle path constraint).
- CACHE_EN=0: the hit term is forced to 0.

Test Plan:
- Reset, then MULHU rs1=0xFFFFFFFF rs2=0xFFFFFFFF (MUL_CYCLES=2) → busy in cycles 1–2, mul_op=3, done in cycle 3, rd_data=0xFFFFFFFE.
- Next cycle, MUL with the same operands → cache hit: done in cycle 1, rd_data=0x00000001, busy never asserted.
- MULH 0x80000000×0x80000000 → rd_data=0x40000000. Then MULHSU with the same operands → miss (op differs), mul_op=2, rd_data=0xC0000000.
- MUL 7×6, kill asserted in cycle 1 → no done, IDLE in cycle 2, rd_data unchanged. Repeat MUL 7×6 → miss, done in cycle 3, rd_data=0x0000002A. start asserted during CALC is ignored. start in the DONE cycle is accepted.
- rst=0 asynchronously mid-CALC → done=0, busy=0, rd_data=0 immediately. After release, the same request misses with full latency.
- CACHE_EN=0: repeat the hit scenario → miss, done in cycle 3, same rd_data value.
